morse_matcher: RTL and testbench

MORSE_MATCHER -- requirements
Module: morse_matcher

---
 rtl/morse_matcher.sv | 219 +++++++++++++++++++++
 tb/tb_morse_matcher.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_matcher.sv
// morse_matcher -- two-player morse code guessing game.
//
// Player 1 presents a code on `target` and pulses `start`. The code is
// latched during the single LOAD cycle. Player 2 then enters dots and
// lines, which are matched slot by slot starting at slot 0. A wrong symbol
// costs one try and restarts the code from slot 0. Running out of tries,
// or giving up, ends the round in LOSE. Matching every slot ends it in WIN.
// Empty slots (00) are skipped automatically at one slot per cycle.
//
// Optional feature: define MORSE_MATCHER_TIMEOUT_EN to add an idle timeout.
// While waiting on a symbol, TIMEOUT_CYCLES idle MATCH cycles count as one
// wrong symbol.
//
// Ports:
//   clock      : single clock; all logic runs on its rising edge
//   reset      : synchronous, active-high reset
//   start      : level-sampled; latch target and begin a round
//   target     : player 1 code; slot k = bits [2*SYMBOLS-1-2k -: 2]
//   sym_dot    : one-cycle pulse, player 2 entered a dot  (code 01)
//   sym_line   : one-cycle pulse, player 2 entered a line (code 11)
//   give_up    : abandon the current round
//   q          : player 2's accepted symbols, newest in the LSBs
//   correct    : per-symbol result pulse (00 neutral, 01 correct, 10 incorrect)
//   complete   : high only in WIN
//   failed     : high only in LOSE
//   tries_left : remaining attempts
//   busy       : high in LOAD and MATCH
module morse_matcher #(
    parameter int SYMBOLS        = 5,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [2*SYMBOLS-1:0]             target,
    input  logic                             sym_dot,
    input  logic                             sym_line,
    input  logic                             give_up,
    output logic [2*SYMBOLS-1:0]             q,
    output logic [1:0]                       correct,
    output logic                             complete,
    output logic                             failed,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
    output logic                             busy
);

    localparam int QW = 2 * SYMBOLS;
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int PW = $clog2(SYMBOLS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MATCH,
        WIN,
        LOSE
    } state_t;

    state_t          state, state_next;
    logic [QW-1:0]   shadow, shadow_next;
    logic [PW-1:0]   ptr, ptr_next, ptr_inc;
    logic [QW-1:0]   q_next;
    logic [TW-1:0]   tries_next;
    logic [1:0]      correct_next;
    logic [1:0]      cur_slot;
    logic [1:0]      sym_code;
    logic            sym_single;
    logic            miss;

`ifdef MORSE_MATCHER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]   tmo_count, tmo_count_next;
    logic            tmo_hit;

    assign tmo_hit = (tmo_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_count <= '0;
        end else begin
            tmo_count <= tmo_count_next;
        end
    end
`endif

    // Pressing both buttons in the same cycle is ambiguous and is ignored.
    assign sym_single = sym_dot ^ sym_line;
    assign sym_code   = sym_dot ? 2'b01 : 2'b11;
    assign ptr_inc    = ptr + PW'(1);

    // Slot currently being matched; the pointer may sit at SYMBOLS briefly,
    // so the selection is guarded rather than a raw variable part-select.
    always_comb begin
        cur_slot = 2'b00;
        for (int k = 0; k < SYMBOLS; k++) begin
            if (ptr == PW'(k)) begin
                cur_slot = shadow[QW-1-2*k -: 2];
            end
        end
    end

    // Next-state and datapath decisions. A wrong symbol (or a timeout) only
    // raises `miss`; the shared penalty is applied once after the case.
    always_comb begin
        state_next   = state;
        shadow_next  = shadow;
        ptr_next     = ptr;
        q_next       = q;
        tries_next   = tries_left;
        correct_next = 2'b00;
        miss         = 1'b0;
`ifdef MORSE_MATCHER_TIMEOUT_EN
        tmo_count_next = tmo_count;
`endif

        case (state)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end

            LOAD: begin
                shadow_next = target;
                ptr_next    = '0;
                q_next      = '0;
                tries_next  = TW'(MAX_TRIES);
                state_next  = MATCH;
`ifdef MORSE_MATCHER_TIMEOUT_EN
                tmo_count_next = '0;
`endif
            end

            MATCH: begin
                if (start) begin
                    state_next = LOAD;
                end else if (give_up) begin
                    state_next = LOSE;
                end else if (ptr == PW'(SYMBOLS)) begin
                    state_next = WIN;
                end else if (cur_slot == 2'b00) begin
                    // Empty slot: skip it; any symbol this cycle is dropped.
                    ptr_next = ptr_inc;
                    if (ptr_inc == PW'(SYMBOLS)) begin
                        state_next = WIN;
                    end
                end else if (sym_single) begin
`ifdef MORSE_MATCHER_TIMEOUT_EN
                    tmo_count_next = '0;
`endif
                    if (sym_code == cur_slot) begin
                        q_next       = (q << 2) | QW'(sym_code);
                        ptr_next     = ptr_inc;
                        correct_next = 2'b01;
                        // Finishing the last slot wins immediately.
                        if (ptr_inc == PW'(SYMBOLS)) begin
                            state_next = WIN;
                        end
                    end else begin
                        miss = 1'b1;
                    end
                end else begin
`ifdef MORSE_MATCHER_TIMEOUT_EN
                    if (tmo_hit) begin
                        miss           = 1'b1;
                        tmo_count_next = '0;
                    end else begin
                        tmo_count_next = tmo_count + CW'(1);
                    end
`endif
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (miss) begin
            correct_next = 2'b10;
            q_next       = '0;
            ptr_next     = '0;
            if (tries_left <= TW'(1)) begin
                tries_next = '0;
                state_next = LOSE;
            end else begin
                tries_next = tries_left - TW'(1);
            end
        end
    end

    // State and output registers. The status flags are decoded from the
    // next state so they are true flops aligned with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shadow     <= '0;
            ptr        <= '0;
            q          <= '0;
            tries_left <= TW'(MAX_TRIES);
            correct    <= 2'b00;
            complete   <= 1'b0;
            failed     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            shadow     <= shadow_next;
            ptr        <= ptr_next;
            q          <= q_next;
            tries_left <= tries_next;
            correct    <= correct_next;
            complete   <= (state_next == WIN);
            failed     <= (state_next == LOSE);
            busy       <= (state_next == LOAD) || (state_next == MATCH);
        end
    end

endmodule

// File: tb/tb_morse_matcher.sv
// tb_morse_matcher -- self-checking bench for morse_matcher.
//
// A game-level model (slot array, queue of accepted symbols, try count)
// predicts every output after every clock. Directed scenarios cover the
// documented examples, followed by a randomized session.
// Build with MORSE_MATCHER_TIMEOUT_EN defined to also exercise the idle
// timeout with TIMEOUT_CYCLES=8.
module tb_morse_matcher;

    localparam int SYMBOLS   = 5;
    localparam int MAX_TRIES = 3;
    localparam int QW        = 2 * SYMBOLS;
    localparam int TW        = $clog2(MAX_TRIES + 1);
`ifdef MORSE_MATCHER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam int TB_TIMEOUT = 50000000;
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_PLAY = 2;
    localparam int PH_WON  = 3;
    localparam int PH_LOST = 4;

    logic           clock;
    logic           reset;
    logic           start;
    logic [QW-1:0]  target;
    logic           sym_dot;
    logic           sym_line;
    logic           give_up;
    logic [QW-1:0]  q;
    logic [1:0]     correct;
    logic           complete;
    logic           failed;
    logic [TW-1:0]  tries_left;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    // Game-level reference state.
    int m_phase;
    int m_code[SYMBOLS];
    int m_pos;
    int m_acc[$];
    int m_tries;
    int m_correct;
    int m_timer;

    morse_matcher #(
        .SYMBOLS        (SYMBOLS),
        .MAX_TRIES      (MAX_TRIES),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .target     (target),
        .sym_dot    (sym_dot),
        .sym_line   (sym_line),
        .give_up    (give_up),
        .q          (q),
        .correct    (correct),
        .complete   (complete),
        .failed     (failed),
        .tries_left (tries_left),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [QW-1:0] model_q();
        logic [QW-1:0] v;
        v = '0;
        foreach (m_acc[i]) v = (v << 2) | QW'(m_acc[i]);
        return v;
    endfunction

    task automatic model_miss();
        m_acc.delete();
        m_pos     = 0;
        m_correct = 2;
        m_timer   = 0;
        if (m_tries == 1) begin
            m_tries = 0;
            m_phase = PH_LOST;
        end else begin
            m_tries--;
        end
    endtask

    task automatic model_clock(input logic r, input logic s, input logic d,
                               input logic l, input logic g, input logic [QW-1:0] tgt);
        int sym;
        if (r) begin
            m_phase = PH_IDLE; m_pos = 0; m_acc.delete();
            m_tries = MAX_TRIES; m_correct = 0; m_timer = 0;
            return;
        end
        m_correct = 0;
        case (m_phase)
            PH_LOAD: begin
                for (int k = 0; k < SYMBOLS; k++) m_code[k] = int'(tgt[QW-1-2*k -: 2]);
                m_pos = 0; m_acc.delete(); m_tries = MAX_TRIES; m_timer = 0;
                m_phase = PH_PLAY;
            end
            PH_PLAY: begin
                if (s) m_phase = PH_LOAD;
                else if (g) m_phase = PH_LOST;
                else if (m_pos >= SYMBOLS) m_phase = PH_WON;
                else if (m_code[m_pos] == 0) begin
                    m_pos++;
                    if (m_pos == SYMBOLS) m_phase = PH_WON;
                end else if (d != l) begin
                    sym = d ? 1 : 3;
                    m_timer = 0;
                    if (sym == m_code[m_pos]) begin
                        m_acc.push_back(sym);
                        m_pos++;
                        m_correct = 1;
                        if (m_pos == SYMBOLS) m_phase = PH_WON;
                    end else begin
                        model_miss();
                    end
                end else if (TIMEOUT_ON) begin
                    if (m_timer == TB_TIMEOUT - 1) model_miss();
                    else m_timer++;
                end
            end
            default: begin
                if (s) m_phase = PH_LOAD;
            end
        endcase
    endtask

    task automatic check_output(input string tag);
        check_value({tag, ".q"}, 32'(q), 32'(model_q()));
        check_value({tag, ".correct"}, 32'(correct), 32'(m_correct));
        check_value({tag, ".complete"}, 32'(complete), 32'(m_phase == PH_WON));
        check_value({tag, ".failed"}, 32'(failed), 32'(m_phase == PH_LOST));
        check_value({tag, ".busy"}, 32'(busy),
                    32'((m_phase == PH_LOAD) || (m_phase == PH_PLAY)));
        check_value({tag, ".tries"}, 32'(tries_left), 32'(m_tries));
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit later.
    task automatic apply_stimulus(input string tag, input logic r, input logic s,
                                  input logic d, input logic l, input logic g);
        reset = r; start = s; sym_dot = d; sym_line = l; give_up = g;
        @(posedge clock);
        model_clock(r, s, d, l, g, target);
        #1;
        check_output(tag);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [QW-1:0] t_main;
        logic          rr, rs, rd, rl, rg;
        int            pick;
        t_main = 10'b01_11_01_00_00;
        target = t_main;
        reset = 1'b1; start = 1'b0; sym_dot = 1'b0; sym_line = 1'b0; give_up = 1'b0;

        // Reset state
        apply_stimulus("rst", 1, 0, 0, 0, 0);
        check_value("rst.tries_const", 32'(tries_left), 32'd3);
        check_value("rst.busy_const", 32'(busy), 32'd0);
        check_value("rst.q_const", 32'(q), 32'd0);
        apply_stimulus("idle_sym", 0, 0, 1, 0, 0);
        check_value("idle_sym.correct", 32'(correct), 32'd0);

        // Straight win
        apply_stimulus("win.start", 0, 1, 0, 0, 0);
        check_value("win.load_busy", 32'(busy), 32'd1);
        apply_stimulus("win.load", 0, 0, 0, 0, 0);
        apply_stimulus("win.dot", 0, 0, 1, 0, 0);
        check_value("win.c1", 32'(correct), 32'd1);
        apply_stimulus("win.line", 0, 0, 0, 1, 0);
        check_value("win.c2", 32'(correct), 32'd1);
        apply_stimulus("win.dot2", 0, 0, 1, 0, 0);
        check_value("win.c3", 32'(correct), 32'd1);
        apply_stimulus("win.skip1", 0, 0, 0, 0, 0);
        check_value("win.not_yet", 32'(complete), 32'd0);
        apply_stimulus("win.skip2", 0, 0, 0, 0, 0);
        check_value("win.complete", 32'(complete), 32'd1);
        check_value("win.q", 32'(q), 32'h01D);

        // One miss then recover
        apply_stimulus("miss.start", 0, 1, 0, 0, 0);
        apply_stimulus("miss.load", 0, 0, 0, 0, 0);
        apply_stimulus("miss.line", 0, 0, 0, 1, 0);
        check_value("miss.correct", 32'(correct), 32'd2);
        check_value("miss.tries", 32'(tries_left), 32'd2);
        check_value("miss.q", 32'(q), 32'd0);
        apply_stimulus("miss.dot", 0, 0, 1, 0, 0);
        apply_stimulus("miss.line2", 0, 0, 0, 1, 0);
        apply_stimulus("miss.dot2", 0, 0, 1, 0, 0);
        idle_cycles("miss.skip", 2);
        check_value("miss.complete", 32'(complete), 32'd1);
        check_value("miss.hold_tries", 32'(tries_left), 32'd2);

        // Lose on three misses
        apply_stimulus("lose.start", 0, 1, 0, 0, 0);
        apply_stimulus("lose.load", 0, 0, 0, 0, 0);
        check_value("lose.tries3", 32'(tries_left), 32'd3);
        apply_stimulus("lose.m1", 0, 0, 0, 1, 0);
        apply_stimulus("lose.m2", 0, 0, 0, 1, 0);
        check_value("lose.tries1", 32'(tries_left), 32'd1);
        apply_stimulus("lose.m3", 0, 0, 0, 1, 0);
        check_value("lose.tries0", 32'(tries_left), 32'd0);
        check_value("lose.failed", 32'(failed), 32'd1);
        apply_stimulus("lose.ignored", 0, 0, 1, 0, 0);
        check_value("lose.ignored_c", 32'(correct), 32'd0);
        apply_stimulus("lose.restart", 0, 1, 0, 0, 0);
        apply_stimulus("lose.load", 0, 0, 0, 0, 0);
        check_value("lose.reload_tries", 32'(tries_left), 32'd3);

        // Reset mid-round, then simultaneous dot+line
        apply_stimulus("rmid.dot", 0, 0, 1, 0, 0);
        apply_stimulus("rmid.line", 0, 0, 0, 1, 0);
        check_value("rmid.q2", 32'(q), 32'h007);
        apply_stimulus("rmid.reset", 1, 0, 0, 0, 0);
        check_value("rmid.q", 32'(q), 32'd0);
        check_value("rmid.busy", 32'(busy), 32'd0);
        apply_stimulus("both.start", 0, 1, 0, 0, 0);
        apply_stimulus("both.load", 0, 0, 0, 0, 0);
        apply_stimulus("both.pulse", 0, 0, 1, 1, 0);
        check_value("both.correct", 32'(correct), 32'd0);
        check_value("both.tries", 32'(tries_left), 32'd3);
        apply_stimulus("both.dot", 0, 0, 1, 0, 0);
        check_value("both.dot_ok", 32'(correct), 32'd1);

        // Target changes after LOAD have no effect
        target = 10'b11_11_11_11_11;
        apply_stimulus("late.line", 0, 0, 0, 1, 0);
        check_value("late.line_ok", 32'(correct), 32'd1);
        apply_stimulus("late.dot", 0, 0, 1, 0, 0);
        check_value("late.dot_ok", 32'(correct), 32'd1);
        idle_cycles("late.skip", 2);
        check_value("late.complete", 32'(complete), 32'd1);

        // All-empty target wins SYMBOLS cycles after entering MATCH
        target = '0;
        apply_stimulus("empty.start", 0, 1, 0, 0, 0);
        apply_stimulus("empty.load", 0, 0, 0, 0, 0);
        idle_cycles("empty.run", SYMBOLS - 1);
        check_value("empty.not_yet", 32'(complete), 32'd0);
        apply_stimulus("empty.last", 0, 0, 0, 0, 0);
        check_value("empty.complete", 32'(complete), 32'd1);

        // Give up
        target = t_main;
        apply_stimulus("gu.start", 0, 1, 0, 0, 0);
        apply_stimulus("gu.load", 0, 0, 0, 0, 0);
        apply_stimulus("gu.give", 0, 0, 0, 0, 1);
        check_value("gu.failed", 32'(failed), 32'd1);

`ifdef MORSE_MATCHER_TIMEOUT_EN
        apply_stimulus("tmo.start", 0, 1, 0, 0, 0);
        apply_stimulus("tmo.load", 0, 0, 0, 0, 0);
        idle_cycles("tmo.wait", TB_TIMEOUT - 1);
        check_value("tmo.quiet", 32'(correct), 32'd0);
        apply_stimulus("tmo.hit", 0, 0, 0, 0, 0);
        check_value("tmo.correct", 32'(correct), 32'd2);
        check_value("tmo.tries", 32'(tries_left), 32'd2);
`endif

        // Randomized session; symbols are biased toward the right answer
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < SYMBOLS; k++) begin
                pick = $urandom_range(0, 3);
                target[QW-1-2*k -: 2] = (pick == 0) ? 2'b00 : ((pick == 1) ? 2'b01 : 2'b11);
            end
            rr = ($urandom_range(0, 149) == 0);
            rs = ($urandom_range(0, 39) == 0);
            rg = ($urandom_range(0, 99) == 0);
            rd = 1'b0; rl = 1'b0;
            pick = $urandom_range(0, 9);
            if (pick < 5 && m_phase == PH_PLAY && m_pos < SYMBOLS && m_code[m_pos] != 0) begin
                rd = (m_code[m_pos] == 1);
                rl = (m_code[m_pos] == 3);
            end else if (pick == 5) begin
                rd = 1'b1;
            end else if (pick == 6) begin
                rl = 1'b1;
            end else if (pick == 7) begin
                rd = 1'b1; rl = 1'b1;
            end
            apply_stimulus("rand", rr, rs, rd, rl, rg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
